// File: rtl/pu_seq_ctrl.sv
// Operand sequencer for the PU: gathers four operands from a serial stream,
// fires one PU job, waits the pipeline latency and holds the result.
module pu_seq_ctrl #(
    parameter int XLEN   = 5,
    parameter int PU_LAT = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_data,
    output logic             in_ready,
    output logic [XLEN-1:0]  num1,
    output logic [XLEN-1:0]  num2,
    output logic [XLEN-1:0]  num3,
    output logic [XLEN-1:0]  num4,
    output logic             pu_load,
    input  logic [XLEN-1:0]  pu_result,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] job_cnt
);

    localparam int LAT_W = $clog2(PU_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PU_LAT - 1);

    typedef enum logic [1:0] {
        COLLECT,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [XLEN-1:0]  num_q [4];
    logic [XLEN-1:0]  num_d [4];
    logic [XLEN-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0] job_q, job_d;

    // Handshake/strobe outputs decode from registered state only
    assign in_ready  = (state_q == COLLECT);
    assign pu_load   = (state_q == ISSUE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != COLLECT) || (idx_q != 2'd0);
    assign num1      = num_q[0];
    assign num2      = num_q[1];
    assign num3      = num_q[2];
    assign num4      = num_q[3];
    assign out_data  = out_data_q;
    assign job_cnt   = job_q;

    // Next-state logic; flush overrides everything except held operands
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        num_d      = num_q;
        out_data_d = out_data_q;
        job_d      = job_q;
        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    num_d[idx_q] = in_data;
                    idx_d        = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    out_data_d = pu_result;
                    state_d    = HOLD;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    job_d   = job_q + 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        if (flush) begin
            state_d    = COLLECT;
            idx_d      = 2'd0;
            num_d      = num_q;
            out_data_d = out_data_q;
            job_d      = job_q;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            idx_q      <= 2'd0;
            lat_q      <= '0;
            num_q      <= '{default: '0};
            out_data_q <= '0;
            job_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            num_q      <= num_d;
            out_data_q <= out_data_d;
            job_q      <= job_d;
        end
    end

endmodule

// File: tb/tb_pu_seq_ctrl.sv
// Scoreboard bench for pu_seq_ctrl with a latency-accurate PU model.
// Expected results are queued at stimulus time and popped on out handshakes.
module tb_pu_seq_ctrl;

    localparam int XLEN   = 5;
    localparam int PU_LAT = 3;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [XLEN-1:0]  in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  num1, num2, num3, num4;
    logic             pu_load;
    logic [XLEN-1:0]  pu_result;
    logic             out_valid;
    logic [XLEN-1:0]  out_data;
    logic             busy;
    logic [CNT_W-1:0] job_cnt;

    pu_seq_ctrl #(.XLEN(XLEN), .PU_LAT(PU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .pu_load(pu_load), .pu_result(pu_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0]  exp_q [$];
    logic [CNT_W-1:0] jc = '0;
    logic [XLEN-1:0]  en [4] = '{default: '0};

    // PU model: result valid only in the cycle PU_LAT after pu_load,
    // complemented garbage in every other cycle.
    logic [PU_LAT-1:0] vld = '0;
    logic [XLEN-1:0]   fval = '0;
    always @(posedge clk) begin
        vld <= {vld[PU_LAT-2:0], pu_load};
        if (pu_load) fval <= num1 ^ num2 ^ num3 ^ num4 ^ 5'h12;
    end
    assign pu_result = vld[PU_LAT-1] ? fval : ~fval;

    function automatic logic [XLEN-1:0] pu_f(input logic [XLEN-1:0] a, b, c, d);
        return a ^ b ^ c ^ d ^ 5'h12;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a handshake happens at the next posedge
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !flush) begin
            check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [XLEN-1:0] o0, o1, o2, o3,
                        input logic [6:0] pat, input int plen);
        logic [XLEN-1:0] o [4];
        int k;
        o = '{o0, o1, o2, o3};
        k = 0;
        for (int c = 0; c < plen; c++) begin
            if (pat[plen-1-c]) begin
                in_valid = 1'b1;
                in_data  = o[k];
                k++;
            end else begin
                in_valid = 1'b0;
                in_data  = 5'h1E;
            end
            check("in_ready_col", 32'(in_ready), 32'd1);
            check("pu_load_col", 32'(pu_load), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        en = o;
        exp_q.push_back(pu_f(o0, o1, o2, o3));
        check("num1", 32'(num1), 32'(o0));
        check("num2", 32'(num2), 32'(o1));
        check("num3", 32'(num3), 32'(o2));
        check("num4", 32'(num4), 32'(o3));
        check("pu_load_issue", 32'(pu_load), 32'd1);
        check("in_ready_issue", 32'(in_ready), 32'd0);
        check("busy_issue", 32'(busy), 32'd1);
    endtask

    task automatic wait_out();
        for (int k = 0; k < PU_LAT; k++) begin
            tick();
            check("ov_early", 32'(out_valid), 32'd0);
            check("pu_load_pulse", 32'(pu_load), 32'd0);
            check("in_ready_wait", 32'(in_ready), 32'd0);
        end
        tick();
        check("ov_lat", 32'(out_valid), 32'd1);
        check("out_data_cap", 32'(out_data), 32'(exp_q[0]));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        jc++;
        check("ov_clr", 32'(out_valid), 32'd0);
        check("in_ready_ret", 32'(in_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("job_cnt", 32'(job_cnt), 32'(jc));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) tick();
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        tick();
        check("rel_ov", 32'(out_valid), 32'd0);
        check("rel_pu_load", 32'(pu_load), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_job_cnt", 32'(job_cnt), 32'd0);
        check("rel_nums", 32'({num1, num2, num3, num4}), 32'd0);
        check("rel_out_data", 32'(out_data), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);

        // Back-to-back operands, known result
        feed(5'h11, 5'h0A, 5'h1F, 5'h03, 7'b0001111, 4);
        wait_out();
        check("t2_result", 32'(out_data), 32'h15);
        consume();

        // Gapped in_valid stream
        feed(5'h04, 5'h1C, 5'h09, 5'h16, 7'b1001101, 7);
        wait_out();
        consume();
        repeat (3) begin
            tick();
            check("pu_load_once", 32'(pu_load), 32'd0);
        end

        // Output backpressure with junk on the input
        feed(5'h07, 5'h13, 5'h1A, 5'h02, 7'b0001111, 4);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 5'($urandom);
            tick();
            check("hold_ov", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp_q[0]));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_nums", 32'({num1, num2, num3, num4}),
                  32'({en[0], en[1], en[2], en[3]}));
        end
        in_valid = 1'b0;
        consume();

        // Flush in the second WAIT cycle
        feed(5'h0F, 5'h10, 5'h01, 5'h1D, 7'b0001111, 4);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(exp_q.pop_back());
        check("fl_ov", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_job_cnt", 32'(job_cnt), 32'(jc));
        for (int i = 0; i < PU_LAT + 2; i++) begin
            tick();
            check("fl_no_ov", 32'(out_valid), 32'd0);
        end

        // Flush coincident with out handshake
        feed(5'h05, 5'h0B, 5'h18, 5'h14, 7'b0001111, 4);
        wait_out();
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check("flo_ov", 32'(out_valid), 32'd0);
        check("flo_job_cnt", 32'(job_cnt), 32'(jc));
        check("flo_in_ready", 32'(in_ready), 32'd1);

        // Flush coincident with an input handshake
        in_valid = 1'b1;
        in_data = 5'h0C;
        tick();
        in_data = 5'h19;
        tick();
        in_data = 5'h06;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fli_num1", 32'(num1), 32'h0C);
        check("fli_num2", 32'(num2), 32'h19);
        check("fli_num3", 32'(num3), 32'(en[2]));
        check("fli_busy", 32'(busy), 32'd0);
        feed(5'h1B, 5'h08, 5'h12, 5'h0E, 7'b0001111, 4);
        wait_out();
        consume();

        // Asynchronous reset mid-WAIT
        feed(5'h03, 5'h17, 5'h0D, 5'h11, 7'b0001111, 4);
        tick();
        #2 rst = 1'b0;
        #1;
        jc = '0;
        exp_q.delete();
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_pu_load", 32'(pu_load), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_job_cnt", 32'(job_cnt), 32'd0);
        check("arst_nums", 32'({num1, num2, num3, num4}), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;
        repeat (PU_LAT + 1) begin
            tick();
            check("arst_no_ov", 32'(out_valid), 32'd0);
        end

        // 256 jobs: counter wraps back to zero
        for (int j = 0; j < 256; j++) begin
            logic [XLEN-1:0] a, b, c, d;
            a = 5'($urandom);
            b = 5'($urandom);
            c = 5'($urandom);
            d = 5'($urandom);
            feed(a, b, c, d, 7'b0001111, 4);
            wait_out();
            consume();
        end
        check("wrap", 32'(job_cnt), 32'd0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
